// File: rtl/counter_pkg.sv
// Shared constants for the bounded counter family: overflow modes and default width.
package counter_pkg;
  localparam int unsigned CNT_DEFAULT_WIDTH = 8;
  localparam logic        CNT_WRAP          = 1'b0;
  localparam logic        CNT_SAT           = 1'b1;
endpackage

// File: rtl/bounded_counter_next.sv
// Next-state logic for bounded_counter: purely combinational, zero latency.
// Priority: cfg_err > load > (inc xor dec) > hold. No backpressure.
module bounded_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sat,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_q_n,
  output logic             o_ovf_n,
  output logic             o_unf_n
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_clamp;
  logic             w_over;
  logic             w_under;
  logic             w_cfg_err;
  logic             w_step_zero;

  // Sum keeps the carry so a wrap past 2^WIDTH still reads as an overflow.
  assign w_sum       = {1'b0, i_q} + {1'b0, i_step};
  assign w_diff      = i_q - i_step;
  assign w_over      = (w_sum > {1'b0, i_hi});
  assign w_under     = (i_q < i_step) || (w_diff < i_lo);
  assign w_cfg_err   = (i_lo > i_hi);
  assign w_step_zero = (i_step == '0);
  assign w_clamp     = (i_d < i_lo) ? i_lo : ((i_d > i_hi) ? i_hi : i_d);

  always_comb begin
    o_q_n   = i_q;
    o_ovf_n = 1'b0;
    o_unf_n = 1'b0;
    if (!w_cfg_err) begin
      if (i_load) begin
        o_q_n = w_clamp;
      end else if ((i_inc ^ i_dec) && !w_step_zero) begin
        if (i_inc) begin
          if (w_over) begin
            o_ovf_n = 1'b1;
            o_q_n   = (i_sat == CNT_SAT) ? i_hi : i_lo;
          end else begin
            o_q_n = w_sum[WIDTH-1:0];
          end
        end else begin
          if (w_under) begin
            o_unf_n = 1'b1;
            o_q_n   = (i_sat == CNT_SAT) ? i_lo : i_hi;
          end else begin
            o_q_n = w_diff;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bounded_counter.sv
// Up/down counter with runtime bounds, step and wrap/saturate mode; q/ovf/unf 1-cycle latency.
// Flags at_hi/at_lo/cfg_err are combinational from q/lo/hi. No backpressure.
module bounded_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = CNT_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_q,
  output logic             o_ovf,
  output logic             o_unf,
  output logic             o_at_hi,
  output logic             o_at_lo,
  output logic             o_cfg_err
);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] w_q_n;
  logic             w_ovf_n;
  logic             w_unf_n;

  bounded_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_q     (r_q),
    .i_step  (i_step),
    .i_lo    (i_lo),
    .i_hi    (i_hi),
    .i_d     (i_d),
    .i_sat   (i_sat),
    .i_inc   (i_inc),
    .i_dec   (i_dec),
    .i_load  (i_load),
    .o_q_n   (w_q_n),
    .o_ovf_n (w_ovf_n),
    .o_unf_n (w_unf_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= RST_VAL;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_q   <= w_q_n;
      r_ovf <= w_ovf_n;
      r_unf <= w_unf_n;
    end
  end

  assign o_q       = r_q;
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;
  assign o_at_hi   = (r_q == i_hi);
  assign o_at_lo   = (r_q == i_lo);
  assign o_cfg_err = (i_lo > i_hi);

endmodule
